// File: rtl/spi_transmitter.sv
// SPI mode-0 master transmitter: bytes in over valid/ready, MSB first on MOSI, CS_N held across bursts.
// Define SPI_TX_MISO_EN for the full-duplex receive path (MISO, RX_DATA, RX_VALID).
module spi_transmitter #(
  parameter int INTERVAL = 125
) (
  input  logic       SCLK,
  input  logic       RST,
  input  logic [7:0] IN_DATA,
  input  logic       IN_VALID,
  output logic       IN_READY,
  output logic       SPI_CLK,
  output logic       MOSI,
  output logic       CS_N,
  output logic       DONE
`ifdef SPI_TX_MISO_EN
  ,
  input  logic       MISO,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID
`endif
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t      state;
  logic [31:0] count;
  logic [6:0]  shreg;
  logic [2:0]  bitcnt;
  logic        tick;
  logic        accept;

  assign tick     = (count == 32'(INTERVAL - 1));
  assign IN_READY = (state == IDLE) || ((state == HOLD) && tick);
  assign accept   = IN_VALID && IN_READY;

  // MOSI carries bit 7 from the load onward; shreg holds the remaining seven bits.
  always_ff @(posedge SCLK) begin
    if (!RST) begin
      state   <= IDLE;
      count   <= '0;
      shreg   <= '0;
      bitcnt  <= '0;
      SPI_CLK <= 1'b0;
      MOSI    <= 1'b0;
      CS_N    <= 1'b1;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;

      if (state == IDLE || tick) begin
        count <= '0;
      end else begin
        count <= count + 32'd1;
      end

      if (accept) begin
        shreg  <= IN_DATA[6:0];
        MOSI   <= IN_DATA[7];
        CS_N   <= 1'b0;
        bitcnt <= '0;
        state  <= SETUP;
      end else begin
        case (state)
          SETUP: begin
            if (tick) begin
              SPI_CLK <= 1'b1;
              state   <= SHIFT;
            end
          end
          SHIFT: begin
            if (tick) begin
              if (!SPI_CLK) begin
                SPI_CLK <= 1'b1;
              end else begin
                SPI_CLK <= 1'b0;
                bitcnt  <= bitcnt + 3'd1;
                if (bitcnt != 3'd7) begin
                  MOSI  <= shreg[6];
                  shreg <= {shreg[5:0], 1'b0};
                end else begin
                  DONE  <= 1'b1;
                  state <= HOLD;
                end
              end
            end
          end
          HOLD: begin
            // A tick without a new byte ends the burst.
            if (tick) begin
              CS_N  <= 1'b1;
              MOSI  <= 1'b0;
              state <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_TX_MISO_EN
  logic [7:0] rx_shreg;
  logic       rise;
  logic       last_fall;

  assign rise      = tick && ((state == SETUP) || ((state == SHIFT) && !SPI_CLK));
  assign last_fall = tick && (state == SHIFT) && SPI_CLK && (bitcnt == 3'd7);

  always_ff @(posedge SCLK) begin
    if (!RST) begin
      rx_shreg <= '0;
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
    end else begin
      RX_VALID <= 1'b0;
      if (rise) begin
        rx_shreg <= {rx_shreg[6:0], MISO};
      end
      if (last_fall) begin
        RX_DATA  <= rx_shreg;
        RX_VALID <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_transmitter.sv
// Scoreboard bench for spi_transmitter: INTERVAL=4 main instance plus an INTERVAL=2 instance.
module tb_spi_transmitter;

  localparam int INTERVAL = 4;

  typedef struct {
    logic [7:0] data;
    int         hs_edge;
  } exp_t;

  logic       sclk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, spi_clk, mosi, cs_n, done;
  logic [7:0] in_data2 = 8'h00;
  logic       in_valid2 = 1'b0;
  logic       in_ready2, spi_clk2, mosi2, cs_n2, done2;
`ifdef SPI_TX_MISO_EN
  logic [7:0] rx_data, rx_data2;
  logic       rx_valid, rx_valid2;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t exp_q[$];

  spi_transmitter #(.INTERVAL(INTERVAL)) dut (
    .SCLK(sclk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid),
    .IN_READY(in_ready), .SPI_CLK(spi_clk), .MOSI(mosi), .CS_N(cs_n),
    .DONE(done)
`ifdef SPI_TX_MISO_EN
    , .MISO(mosi), .RX_DATA(rx_data), .RX_VALID(rx_valid)
`endif
  );

  spi_transmitter #(.INTERVAL(2)) dut2 (
    .SCLK(sclk), .RST(rst), .IN_DATA(in_data2), .IN_VALID(in_valid2),
    .IN_READY(in_ready2), .SPI_CLK(spi_clk2), .MOSI(mosi2), .CS_N(cs_n2),
    .DONE(done2)
`ifdef SPI_TX_MISO_EN
    , .MISO(mosi2), .RX_DATA(rx_data2), .RX_VALID(rx_valid2)
`endif
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called on a falling clock edge; returns on the falling edge after acceptance, IN_VALID still high.
  task automatic send(input logic [7:0] d);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin
      @(negedge sclk);
      n++;
    end
    check_value("accept_timeout", 32'(n < 2000), 32'd1);
    exp_q.push_back('{d, cyc + 1});
    @(negedge sclk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(cs_n && exp_q.size() == 0) && n < 2000) begin
      @(negedge sclk);
      n++;
    end
    check_value("idle_timeout", 32'(n < 2000), 32'd1);
    repeat (3) @(negedge sclk);
  endtask

  // Monitor: assemble MOSI at SPI_CLK rises, compare against the scoreboard at DONE.
  logic       prev_clk = 1'b0;
  logic       prev_cs = 1'b1;
  logic [7:0] shift_byte = 8'h00;
  int         nbits = 0, rise_cyc = 0, done_cyc = 0;
  int         rise_total = 0, cs_rise_total = 0, done_total = 0, rx_valid_total = 0;
  exp_t       mon_e;

  always @(negedge sclk) begin
    if (!rst) begin
      nbits    = 0;
      prev_clk = 1'b0;
      prev_cs  = 1'b1;
    end else begin
      if (spi_clk && !prev_clk) begin
        rise_total++;
        rise_cyc = cyc;
        if (nbits == 0 && exp_q.size() > 0)
          check_value("first_rise", 32'(cyc - exp_q[0].hs_edge), 32'(INTERVAL));
        check_value("cs_at_rise", cs_n, 1'b0);
        shift_byte = {shift_byte[6:0], mosi};
        nbits++;
      end
      if (!spi_clk && prev_clk)
        check_value("high_len", 32'(cyc - rise_cyc), 32'(INTERVAL));
      if (cs_n && !prev_cs) begin
        cs_rise_total++;
        check_value("cs_release", 32'(cyc - done_cyc), 32'(INTERVAL));
      end
      if (done) begin
        done_total++;
        done_cyc = cyc;
        if (exp_q.size() == 0) begin
          check_value("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          $display("byte sent 0x%02h expected 0x%02h, %0d bits, %0d cycles after handshake",
                   shift_byte, mon_e.data, nbits, cyc - mon_e.hs_edge);
          check_value("byte", shift_byte, mon_e.data);
          check_value("nbits", 32'(nbits), 32'd8);
          check_value("done_lat", 32'(cyc - mon_e.hs_edge), 32'(16 * INTERVAL));
`ifdef SPI_TX_MISO_EN
          check_value("rx_valid", rx_valid, 1'b1);
          check_value("rx_data", rx_data, mon_e.data);
`endif
        end
        nbits = 0;
      end
`ifdef SPI_TX_MISO_EN
      if (rx_valid) rx_valid_total++;
`endif
      prev_clk = spi_clk;
      prev_cs  = cs_n;
    end
  end

  initial begin : main
    int r, n, base_rise, base_cs, base_done;
    logic prev;

    // Reset
    rst = 1'b0;
    repeat (3) @(negedge sclk);
    check_value("rst_spi_clk", spi_clk, 1'b0);
    check_value("rst_mosi", mosi, 1'b0);
    check_value("rst_cs_n", cs_n, 1'b1);
    check_value("rst_done", done, 1'b0);
    check_value("rst_ready", in_ready, 1'b1);
`ifdef SPI_TX_MISO_EN
    check_value("rst_rx_data", rx_data, 8'h00);
    check_value("rst_rx_valid", rx_valid, 1'b0);
`endif
    rst = 1'b1;
    @(negedge sclk);

    // Single byte
    send(8'hA5);
    in_valid = 1'b0;
    check_value("single_cs_low", cs_n, 1'b0);
    check_value("single_ready_busy", in_ready, 1'b0);
    check_value("single_mosi_msb", mosi, 1'b1);
    wait_idle();
    check_value("single_done_count", 32'(done_total), 32'd1);

    // Burst with IN_VALID held
    base_rise = rise_total;
    base_cs   = cs_rise_total;
    base_done = done_total;
    send(8'h3C);
    send(8'hC3);
    in_valid = 1'b0;
    wait_idle();
    check_value("burst_rises", 32'(rise_total - base_rise), 32'd16);
    check_value("burst_cs_rises", 32'(cs_rise_total - base_cs), 32'd1);
    check_value("burst_dones", 32'(done_total - base_done), 32'd2);

    // Busy: valid during SHIFT is refused
    send(8'hA5);
    in_valid = 1'b0;
    repeat (20) @(negedge sclk);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_value("busy_ready", in_ready, 1'b0);
      @(negedge sclk);
    end
    in_valid = 1'b0;
    wait_idle();

    // Abort after third rising edge
    send(8'hA5);
    in_valid = 1'b0;
    r = 0;
    n = 0;
    prev = spi_clk;
    while (r < 3 && n < 500) begin
      @(negedge sclk);
      if (spi_clk && !prev) r++;
      prev = spi_clk;
      n++;
    end
    check_value("abort_wait", 32'(r), 32'd3);
    rst = 1'b0;
    @(negedge sclk);
    check_value("abort_cs_n", cs_n, 1'b1);
    check_value("abort_spi_clk", spi_clk, 1'b0);
    check_value("abort_done", done, 1'b0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    rst = 1'b1;
    base_done = done_total;
    repeat (70) @(negedge sclk);
    check_value("abort_no_done", 32'(done_total), 32'(base_done));
    send(8'h81);
    in_valid = 1'b0;
    wait_idle();

    check_value("queue_empty", 32'(exp_q.size()), 32'd0);
    check_value("total_dones", 32'(done_total), 32'd5);
`ifdef SPI_TX_MISO_EN
    check_value("rx_valid_count", 32'(rx_valid_total), 32'(done_total));
`endif

    // INTERVAL=2 instance
    begin : fast
      int hs, nb, rise_at, k;
      logic [7:0] b;
      logic p, seen;
      check_value("fast_ready", in_ready2, 1'b1);
      in_data2  = 8'hA5;
      in_valid2 = 1'b1;
      hs = cyc + 1;
      @(negedge sclk);
      in_valid2 = 1'b0;
      k = 0; nb = 0; b = 8'h00; p = 1'b0; seen = 1'b0; rise_at = 0;
      while (!seen && k < 300) begin
        if (spi_clk2 && !p) begin
          b = {b[6:0], mosi2};
          nb++;
          rise_at = cyc;
        end
        if (!spi_clk2 && p)
          check_value("fast_high_len", 32'(cyc - rise_at), 32'd2);
        if (done2) begin
          seen = 1'b1;
          $display("fast byte sent 0x%02h, %0d cycles after handshake", b, cyc - hs);
          check_value("fast_byte", b, 8'hA5);
          check_value("fast_nbits", 32'(nb), 32'd8);
          check_value("fast_done_lat", 32'(cyc - hs), 32'd32);
`ifdef SPI_TX_MISO_EN
          check_value("fast_rx_valid", rx_valid2, 1'b1);
          check_value("fast_rx_data", rx_data2, 8'hA5);
`endif
        end
        p = spi_clk2;
        if (!seen) begin
          @(negedge sclk);
          k++;
        end
      end
      check_value("fast_done_seen", seen, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
